tc_pl_cap_data_adc_merge: RTL and testbench

Upstream stage of the capture buffer controller. Pairs free-running ADC0 and ADC1 sample words into one merged word and absorbs inter-channel skew in per-channel FIFOs. Gates the stream with an arm/trigger/complete state machine. Presents the result on the `Gc_merge_data` / `Gc_mereg_datv` / `Gc_mereg_datr` handshake consumed by the capture counter/accumulator.

---
 rtl/tc_pl_cap_pkg.sv | 7 +
 rtl/tc_pl_cap_data_adc_merge_fifo.sv | 43 ++++
 rtl/tc_pl_cap_data_adc_merge.sv | 76 +++++++
 tb/tb_tc_pl_cap_data_adc_merge.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/tc_pl_cap_pkg.sv
// tc_pl_cap_pkg: shared capture-path widths and FSM state encoding
package tc_pl_cap_pkg;
  localparam int ADC_W = 28;
  localparam int ADC0_1 = 2 * ADC_W;
  localparam int FIFO_AW = 2;
  typedef enum logic [1:0] {IDLE, ARMED, RUN} cap_state_e;
endpackage

// File: rtl/tc_pl_cap_data_adc_merge_fifo.sv
// tc_pl_cap_data_adc_merge_fifo: per-channel sync FIFO with flush, full/empty and drop flag
module tc_pl_cap_data_adc_merge_fifo #(
  parameter int W = 28,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic         drop
);
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [2**AW];
  logic wr_ok, rd_ok;
  always_comb begin
    full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty = wr_ptr_q == rd_ptr_q;
    rd_ok = rd_en && !empty;
    // a full FIFO still accepts a word when its head leaves in the same cycle
    wr_ok = wr_en && (!full || rd_ok);
    drop = wr_en && full && !rd_ok;
    wr_ptr_d = flush ? '0 : wr_ptr_q + {{AW{1'b0}}, wr_ok};
    rd_ptr_d = flush ? '0 : rd_ptr_q + {{AW{1'b0}}, rd_ok};
    rd_data = mem_q[rd_ptr_q[AW-1:0]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/tc_pl_cap_data_adc_merge.sv
// tc_pl_cap_data_adc_merge: pairs ADC0/ADC1 words through skew FIFOs under arm/trigger/complete gating
module tc_pl_cap_data_adc_merge
  import tc_pl_cap_pkg::*;
#(
  parameter int ADC_W = tc_pl_cap_pkg::ADC_W,
  parameter int ADC0_1 = tc_pl_cap_pkg::ADC0_1,
  parameter int FIFO_AW = tc_pl_cap_pkg::FIFO_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_arm,
  input  logic              cap_trig,
  input  logic              Gc_cap_cmpt,
  input  logic [ADC_W-1:0]  adc0_data,
  input  logic              adc0_valid,
  input  logic [ADC_W-1:0]  adc1_data,
  input  logic              adc1_valid,
  output logic [ADC0_1-1:0] Gc_merge_data,
  output logic              Gc_mereg_datv,
  input  logic              Gc_mereg_datr,
  output logic              cap_busy,
  output logic              cap_ovf
);
  cap_state_e state_q, state_d;
  logic [ADC0_1-1:0] data_q, data_d;
  logic datv_q, datv_d, ovf_q, ovf_d;
  logic arm_take, cmpt_take, flush, pop, wr0, wr1;
  logic [ADC_W-1:0] rd0, rd1;
  logic full0, full1, empty0, empty1, drop0, drop1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    arm_take = (state_q == IDLE) && cap_arm;
    cmpt_take = (state_q != IDLE) && Gc_cap_cmpt;
    state_d = state_q;
    if (arm_take) state_d = ARMED;
    else if (cmpt_take) state_d = IDLE;
    else if (state_q == ARMED && cap_trig) state_d = RUN;
  end
  always_comb begin
    cap_busy = state_q != IDLE;
  end
  always_comb begin
    flush = arm_take || cmpt_take;
    wr0 = (state_q == RUN) && adc0_valid && !Gc_cap_cmpt;
    wr1 = (state_q == RUN) && adc1_valid && !Gc_cap_cmpt;
    pop = !empty0 && !empty1 && (!datv_q || Gc_mereg_datr) && !flush;
    datv_d = flush ? 1'b0 : pop ? 1'b1 : (datv_q && Gc_mereg_datr) ? 1'b0 : datv_q;
    data_d = pop ? {rd1, rd0} : data_q;
    ovf_d = arm_take ? 1'b0 : ovf_q || drop0 || drop1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      datv_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      data_q <= data_d;
      datv_q <= datv_d;
      ovf_q <= ovf_d;
    end
  end
  tc_pl_cap_data_adc_merge_fifo #(.W(ADC_W), .AW(FIFO_AW)) u_fifo0 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr0), .wr_data(adc0_data), .rd_en(pop),
    .rd_data(rd0), .full(full0), .empty(empty0), .drop(drop0)
  );
  tc_pl_cap_data_adc_merge_fifo #(.W(ADC_W), .AW(FIFO_AW)) u_fifo1 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr1), .wr_data(adc1_data), .rd_en(pop),
    .rd_data(rd1), .full(full1), .empty(empty1), .drop(drop1)
  );
  assign Gc_merge_data = data_q;
  assign Gc_mereg_datv = datv_q;
  assign cap_ovf = ovf_q;
endmodule

// File: tb/tb_tc_pl_cap_data_adc_merge.sv
// tb_tc_pl_cap_data_adc_merge: directed stimulus with a queued scoreboard checked by an output monitor
module tb_tc_pl_cap_data_adc_merge;
  logic clk = 1'b0, rst = 1'b1;
  logic cap_arm = 0, cap_trig = 0, cmpt = 0, datr = 1;
  logic [27:0] adc0_data = 0, adc1_data = 0;
  logic adc0_valid = 0, adc1_valid = 0;
  logic [55:0] data;
  logic datv, cap_busy, cap_ovf;
  logic [55:0] sb_q [$];
  logic [55:0] w0;
  int pass_cnt = 0, tot_cnt = 0;
  tc_pl_cap_data_adc_merge dut (
    .clk(clk), .rst(rst), .cap_arm(cap_arm), .cap_trig(cap_trig), .Gc_cap_cmpt(cmpt),
    .adc0_data(adc0_data), .adc0_valid(adc0_valid), .adc1_data(adc1_data), .adc1_valid(adc1_valid),
    .Gc_merge_data(data), .Gc_mereg_datv(datv), .Gc_mereg_datr(datr),
    .cap_busy(cap_busy), .cap_ovf(cap_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v0, input logic [27:0] d0, input logic v1, input logic [27:0] d1);
    adc0_valid = v0;
    adc0_data = d0;
    adc1_valid = v1;
    adc1_data = d1;
  endtask
  always @(negedge clk) begin
    if (!rst && datv && datr) begin
      if (sb_q.size() == 0) begin
        tot_cnt++;
        $display("FAIL unexpected_output: got %0h required no output", data);
      end else chk("merge_data", {8'h0, data}, {8'h0, sb_q.pop_front()});
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    #2;
    chk("rst_datv", {63'h0, datv}, 64'h0);
    chk("rst_data", {8'h0, data}, 64'h0);
    chk("rst_busy", {63'h0, cap_busy}, 64'h0);
    chk("rst_ovf", {63'h0, cap_ovf}, 64'h0);
    step();
    rst = 1'b0;
    step();
    // basic pairing and latency
    cap_arm = 1; step(); cap_arm = 0;
    chk("busy_after_arm", {63'h0, cap_busy}, 64'h1);
    cap_trig = 1; step(); cap_trig = 0;
    drive(1, 28'h0000001, 1, 28'h1000001);
    sb_q.push_back(56'h10000010000001);
    step(); drive(0, 0, 0, 0);
    chk("lat_n1_datv", {63'h0, datv}, 64'h0);
    step();
    chk("lat_n2_datv", {63'h0, datv}, 64'h1);
    step();
    chk("lat_n3_datv", {63'h0, datv}, 64'h0);
    // adc0 leads adc1 by three words
    for (int n = 1; n <= 8; n++) sb_q.push_back({28'(n), 28'(n)});
    for (int c = 0; c < 11; c++) begin
      drive(c < 8, 28'(c + 1), c >= 3, 28'(c - 2));
      step();
    end
    drive(0, 0, 0, 0);
    repeat (4) step();
    chk("skew_drained", 64'(sb_q.size()), 64'h0);
    chk("skew_no_ovf", {63'h0, cap_ovf}, 64'h0);
    // backpressure: output held, FIFOs fill, overflow
    datr = 0;
    w0 = {28'h10, 28'h10};
    for (int k = 0; k < 5; k++) sb_q.push_back({28'(16 + k), 28'(16 + k)});
    for (int k = 0; k < 10; k++) begin
      drive(1, 28'(16 + k), 1, 28'(16 + k));
      step();
      if (k >= 1) chk("hold", {7'h0, datv, data}, {7'h0, 1'b1, w0});
    end
    drive(0, 0, 0, 0);
    chk("bp_ovf", {63'h0, cap_ovf}, 64'h1);
    datr = 1;
    repeat (8) step();
    chk("bp_drained", 64'(sb_q.size()), 64'h0);
    chk("ovf_sticky", {63'h0, cap_ovf}, 64'h1);
    // gating in IDLE and ARMED, re-arm clears overflow
    cmpt = 1; step(); cmpt = 0;
    chk("busy_after_cmpt", {63'h0, cap_busy}, 64'h0);
    drive(1, 28'hEE, 1, 28'hEE);
    cap_trig = 1; step(); cap_trig = 0;
    step(); drive(0, 0, 0, 0);
    chk("trig_idle_ignored", {63'h0, cap_busy}, 64'h0);
    cap_arm = 1; step(); cap_arm = 0;
    chk("rearm_ovf_clr", {63'h0, cap_ovf}, 64'h0);
    chk("rearm_busy", {63'h0, cap_busy}, 64'h1);
    drive(1, 28'hDD, 1, 28'hDD);
    step(); step(); drive(0, 0, 0, 0);
    repeat (4) step();
    chk("armed_no_out", {63'h0, datv}, 64'h0);
    cap_trig = 1; step(); cap_trig = 0;
    drive(1, 28'h2, 1, 28'h3);
    sb_q.push_back({28'h3, 28'h2});
    step(); drive(0, 0, 0, 0);
    repeat (4) step();
    chk("rearm_drained", 64'(sb_q.size()), 64'h0);
    // complete with a pending word and a queued pair
    datr = 0;
    drive(1, 28'hA, 1, 28'hB); step();
    drive(1, 28'hC, 1, 28'hD); step();
    drive(0, 0, 0, 0); step();
    chk("pending_datv", {63'h0, datv}, 64'h1);
    cmpt = 1; step(); cmpt = 0;
    chk("cmpt_datv", {63'h0, datv}, 64'h0);
    chk("cmpt_busy", {63'h0, cap_busy}, 64'h0);
    datr = 1;
    repeat (4) step();
    chk("cmpt_flushed", {63'h0, datv}, 64'h0);
    cap_arm = 1; step(); cap_arm = 0;
    cap_trig = 1; step(); cap_trig = 0;
    drive(1, 28'h5, 1, 28'h6);
    sb_q.push_back({28'h6, 28'h5});
    step(); drive(0, 0, 0, 0);
    repeat (4) step();
    chk("post_cmpt_drained", 64'(sb_q.size()), 64'h0);
    // async reset mid-stream
    datr = 0;
    for (int k = 0; k < 7; k++) begin
      drive(1, 28'h7, 1, 28'h8);
      step();
    end
    drive(0, 0, 0, 0);
    chk("pre_rst_ovf", {63'h0, cap_ovf}, 64'h1);
    chk("pre_rst_datv", {63'h0, datv}, 64'h1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_datv", {63'h0, datv}, 64'h0);
    chk("arst_data", {8'h0, data}, 64'h0);
    chk("arst_busy", {63'h0, cap_busy}, 64'h0);
    chk("arst_ovf", {63'h0, cap_ovf}, 64'h0);
    step();
    rst = 0;
    datr = 1;
    repeat (3) step();
    chk("final_drained", 64'(sb_q.size()), 64'h0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
